// File: rtl/imm_pkg.sv
// Shared immediate-format constants and encoder FSM state type.
// The datapath extender imports the same ImmSrc codes.
package imm_pkg;

    localparam logic [1:0] IMM8   = 2'b00;
    localparam logic [1:0] IMM12  = 2'b01;
    localparam logic [1:0] BRANCH = 2'b10;
    localparam logic [1:0] ROTIMM = 2'b11;

    localparam logic [31:0] PC_READ_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } imm_state_e;

    // True when v[31:lsb] are all the same bit, i.e. v sign-extends from bit lsb.
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = 32'($signed(v) >>> lsb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Tests one rotation candidate: rotates value left by 2*r and checks it fits in 8 bits.
module imm_rot_check (
    input  logic [31:0] value,
    input  logic [3:0]  r,
    output logic        hit,
    output logic [7:0]  imm8
);

    logic [5:0]  sh;
    logic [31:0] t;

    always_comb begin
        sh   = {1'b0, r, 1'b0};
        // For sh == 0 the right shift by 32 yields zero, giving a plain copy.
        t    = (value << sh) | (value >> (6'd32 - sh));
        hit  = (t[31:8] == 24'd0);
        imm8 = t[7:0];
    end

endmodule

// File: rtl/imm_encoder.sv
// Sequential immediate-field encoder with a 16-step rotated-immediate search.
// Result registers load when EXEC finishes; out_valid follows one cycle later.
module imm_encoder
    import imm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  imm_src,
    input  logic [31:0] value,
    input  logic [31:0] pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] field,
    output logic        ok
);

    imm_state_e  state_q, state_d;
    logic [1:0]  src_q, src_d;
    logic [31:0] value_q, value_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  r_q, r_d;
    logic [23:0] field_q, field_d;
    logic        ok_q, ok_d;
    logic        out_valid_q, out_valid_d;

    logic        rot_hit;
    logic [7:0]  rot_imm8;
    logic [31:0] off;
    logic        res_done;
    logic        res_ok;
    logic [23:0] res_field;

    imm_rot_check u_rot_check (
        .value (value_q),
        .r     (r_q),
        .hit   (rot_hit),
        .imm8  (rot_imm8)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        value_d     = value_q;
        pc_d        = pc_q;
        r_d         = r_q;
        field_d     = field_q;
        ok_d        = ok_q;
        out_valid_d = out_valid_q;
        res_done    = 1'b0;
        res_ok      = 1'b0;
        res_field   = 24'd0;
        off         = value_q - (pc_q + PC_READ_OFFSET);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    src_d   = imm_src;
                    value_d = value;
                    pc_d    = pc;
                    r_d     = 4'd0;
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (src_q)
                    IMM8: begin
                        res_done  = 1'b1;
                        res_ok    = upper_uniform(value_q, 7);
                        res_field = {16'd0, value_q[7:0]};
                    end
                    IMM12: begin
                        res_done  = 1'b1;
                        res_ok    = upper_uniform(value_q, 11);
                        res_field = {12'd0, value_q[11:0]};
                    end
                    BRANCH: begin
                        res_done  = 1'b1;
                        res_ok    = (off[1:0] == 2'b00) && upper_uniform(off, 25);
                        res_field = off[25:2];
                    end
                    ROTIMM: begin
                        if (rot_hit) begin
                            res_done  = 1'b1;
                            res_ok    = 1'b1;
                            res_field = {12'd0, r_q, rot_imm8};
                        end else if (r_q == 4'd15) begin
                            res_done = 1'b1;
                        end else begin
                            r_d = r_q + 4'd1;
                        end
                    end
                    default: ;
                endcase
                if (res_done) begin
                    ok_d    = res_ok;
                    field_d = res_ok ? res_field : 24'd0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            src_q       <= IMM8;
            value_q     <= 32'd0;
            pc_q        <= 32'd0;
            r_q         <= 4'd0;
            field_q     <= 24'd0;
            ok_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            value_q     <= value_d;
            pc_q        <= pc_d;
            r_q         <= r_d;
            field_q     <= field_d;
            ok_q        <= ok_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign field     = field_q;
    assign ok        = ok_q;

endmodule
